// File: rtl/config_arb_pkg.sv
// Shared definitions for the configuration port arbiter.
//   arb_state_e : arbiter FSM states (IDLE / START / OWN)
//   SRC_*       : ActiveSource encodings
//   SYNC_WORD   : sync word the config FSM waits for after FSM_Reset
package config_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_OWN   = 2'd2
    } arb_state_e;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_A    = 2'b01;
    localparam logic [1:0] SRC_B    = 2'b10;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/config_port_arbiter_if.sv
// Bundle of the two configuration sources and the shared config write port.
// Handshake: x_WriteStrobe is a one-cycle valid with no ready; a source may
// only strobe while x_Granted is high, and the arbiter never back-pressures.
// x_ComActive is a level that holds the session open for its whole duration.
//   master : source/consumer side (drives ComActive/WriteData/WriteStrobe)
//   slave  : arbiter side (drives grants and the config write port)
interface config_port_arbiter_if;
    logic        A_ComActive;
    logic [31:0] A_WriteData;
    logic        A_WriteStrobe;
    logic        A_Granted;
    logic        B_ComActive;
    logic [31:0] B_WriteData;
    logic        B_WriteStrobe;
    logic        B_Granted;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        FSM_Reset;
    logic [1:0]  ActiveSource;
    logic        TimeoutEvent;

    modport master (
        output A_ComActive, A_WriteData, A_WriteStrobe,
        output B_ComActive, B_WriteData, B_WriteStrobe,
        input  A_Granted, B_Granted,
        input  WriteData, WriteStrobe, FSM_Reset, ActiveSource, TimeoutEvent
    );

    modport slave (
        input  A_ComActive, A_WriteData, A_WriteStrobe,
        input  B_ComActive, B_WriteData, B_WriteStrobe,
        output A_Granted, B_Granted,
        output WriteData, WriteStrobe, FSM_Reset, ActiveSource, TimeoutEvent
    );
endinterface

// File: rtl/config_arb_watchdog.sv
// Stall watchdog for the current port owner.
//   clk, resetn : clock, synchronous active-low reset
//   clear_i     : zero the count (session start or forwarded word)
//   enable_i    : count this cycle (owner idle in OWN)
//   expire_o    : combinational; high in the cycle the count reaches TimeoutCycles
// TimeoutCycles = 0 disables the watchdog entirely.
module config_arb_watchdog #(
    parameter int unsigned TimeoutCycles = 1000000,
    parameter int unsigned TimeoutWidth  = 20
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam bit                    Enabled  = (TimeoutCycles != 0);
    localparam int unsigned           LimitInt = Enabled ? TimeoutCycles - 1 : 0;
    localparam logic [TimeoutWidth-1:0] Limit  = TimeoutWidth'(LimitInt);

    logic [TimeoutWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !Enabled) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Firing on Limit = TimeoutCycles-1 means the idle cycle that would bring
    // the count to TimeoutCycles is the one that releases the port.
    assign expire_o = Enabled && enable_i && !clear_i && (cnt_q == Limit);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/config_port_arbiter.sv
// Shares the fabric config write port between source A and source B.
// A source owns the port for a whole session; each new grant produces a
// one-cycle FSM_Reset so the config FSM resynchronises on the sync word.
//   CLK, resetn : clock, synchronous active-low reset
//   bus         : sources A/B and the config write port (slave side)
//   dbg_state   : current arbiter FSM state
module config_port_arbiter
    import config_arb_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1000000,
    parameter int unsigned TimeoutWidth  = 20
) (
    input  logic                  CLK,
    input  logic                  resetn,
    config_port_arbiter_if.slave  bus,
    output arb_state_e            dbg_state
);
    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;      // 0 = A, 1 = B
    logic        last_q, last_d;        // source granted most recently
    logic        blk_a_q, blk_a_d;
    logic        blk_b_q, blk_b_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wstrobe_q, wstrobe_d;
    logic        fsm_reset_q, fsm_reset_d;
    logic        timeout_q, timeout_d;

    logic        in_session, own_active, own_strobe, forward;
    logic [31:0] own_data;
    logic        elig_a, elig_b, pick_b;
    logic        wd_clear, wd_enable, wd_expire;

    assign in_session = (state_q != ST_IDLE);
    assign own_active = owner_q ? bus.B_ComActive   : bus.A_ComActive;
    assign own_strobe = owner_q ? bus.B_WriteStrobe : bus.A_WriteStrobe;
    assign own_data   = owner_q ? bus.B_WriteData   : bus.A_WriteData;
    // A strobe coinciding with ComActive falling is dropped.
    assign forward    = in_session && own_active && own_strobe;

    assign elig_a = bus.A_ComActive && !blk_a_q;
    assign elig_b = bus.B_ComActive && !blk_b_q;
    // Round-robin: on a tie the source that was not granted last wins.
    assign pick_b = elig_b && (!elig_a || !last_q);

    assign wd_clear  = (state_q != ST_OWN) || forward;
    assign wd_enable = (state_q == ST_OWN) && !forward;

    config_arb_watchdog #(
        .TimeoutCycles (TimeoutCycles),
        .TimeoutWidth  (TimeoutWidth)
    ) u_watchdog (
        .clk      (CLK),
        .resetn   (resetn),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wstrobe_d   = forward;
        wdata_d     = forward ? own_data : wdata_q;
        fsm_reset_d = 1'b0;
        timeout_d   = 1'b0;
        // A blocked source is released once it drops its session request.
        blk_a_d     = blk_a_q && bus.A_ComActive;
        blk_b_d     = blk_b_q && bus.B_ComActive;

        case (state_q)
            ST_IDLE: begin
                if (elig_a || elig_b) begin
                    state_d     = ST_START;
                    owner_d     = pick_b;
                    last_d      = pick_b;
                    fsm_reset_d = 1'b1;
                end
            end
            ST_START: begin
                state_d = own_active ? ST_OWN : ST_IDLE;
            end
            ST_OWN: begin
                if (!own_active) begin
                    state_d = ST_IDLE;
                end else if (wd_expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    if (owner_q) begin
                        blk_b_d = 1'b1;
                    end else begin
                        blk_a_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            blk_a_q     <= 1'b0;
            blk_b_q     <= 1'b0;
            wdata_q     <= '0;
            wstrobe_q   <= 1'b0;
            fsm_reset_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            blk_a_q     <= blk_a_d;
            blk_b_q     <= blk_b_d;
            wdata_q     <= wdata_d;
            wstrobe_q   <= wstrobe_d;
            fsm_reset_q <= fsm_reset_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.A_Granted    = in_session && !owner_q;
    assign bus.B_Granted    = in_session &&  owner_q;
    assign bus.ActiveSource = !in_session ? SRC_NONE : (owner_q ? SRC_B : SRC_A);
    assign bus.WriteData    = wdata_q;
    assign bus.WriteStrobe  = wstrobe_q;
    assign bus.FSM_Reset    = fsm_reset_q;
    assign bus.TimeoutEvent = timeout_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_config_port_arbiter.sv
// Bench for config_port_arbiter: one instance with a 16-cycle watchdog checked
// against a session-level reference model, one with the watchdog disabled.
module tb_config_port_arbiter;
    import config_arb_pkg::*;

    localparam int T_WD = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    config_port_arbiter_if bus ();
    config_port_arbiter_if bus2 ();
    arb_state_e dbg1, dbg2;

    config_port_arbiter #(.TimeoutCycles(T_WD), .TimeoutWidth(8)) dut (
        .CLK(clk), .resetn(resetn), .bus(bus), .dbg_state(dbg1));

    config_port_arbiter #(.TimeoutCycles(0), .TimeoutWidth(4)) dut_nowd (
        .CLK(clk), .resetn(resetn), .bus(bus2), .dbg_state(dbg2));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: session owner (-1 none), whether the session has just
    // started, idle-cycle count, last winner, blocked sources.
    int          m_owner = -1;
    bit          m_fresh = 0;
    int          m_idle = 0;
    int          m_last = 1;
    bit          m_blk[2];
    logic [31:0] m_wd = '0;
    bit          m_ws = 0, m_fr = 0, m_to = 0;

    task automatic model_edge();
        bit c[2];
        bit s[2];
        logic [31:0] d[2];
        int o, pick;
        c[0] = bus.A_ComActive;  s[0] = bus.A_WriteStrobe;  d[0] = bus.A_WriteData;
        c[1] = bus.B_ComActive;  s[1] = bus.B_WriteStrobe;  d[1] = bus.B_WriteData;
        if (!resetn) begin
            m_owner = -1; m_fresh = 0; m_idle = 0; m_last = 1;
            m_blk[0] = 0; m_blk[1] = 0;
            m_wd = '0; m_ws = 0; m_fr = 0; m_to = 0;
            return;
        end
        m_ws = 0; m_fr = 0; m_to = 0;
        if (m_owner >= 0) begin
            o = m_owner;
            if (c[o] && s[o]) begin m_ws = 1; m_wd = d[o]; end
            if (!c[o]) m_owner = -1;
            else if (m_fresh) begin m_fresh = 0; m_idle = 0; end
            else if (s[o]) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == T_WD) begin m_to = 1; m_blk[o] = 1; m_owner = -1; end
            end
        end else begin
            pick = -1;
            if (c[0] && !m_blk[0] && c[1] && !m_blk[1]) pick = 1 - m_last;
            else if (c[0] && !m_blk[0]) pick = 0;
            else if (c[1] && !m_blk[1]) pick = 1;
            if (pick >= 0) begin
                m_owner = pick; m_last = pick; m_fresh = 1; m_fr = 1; m_idle = 0;
            end
        end
        for (int k = 0; k < 2; k++) if (!c[k]) m_blk[k] = 0;
    endtask

    function automatic logic [38:0] exp_vec();
        logic [1:0] as;
        as = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        return {m_ws, m_fr, m_to, m_owner == 0, m_owner == 1, as, m_wd};
    endfunction

    function automatic logic [38:0] obs_vec();
        return {bus.WriteStrobe, bus.FSM_Reset, bus.TimeoutEvent, bus.A_Granted,
                bus.B_Granted, bus.ActiveSource, bus.WriteData};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit a_act, input bit a_stb, input logic [31:0] a_dat,
                         input bit b_act, input bit b_stb, input logic [31:0] b_dat);
        bus.A_ComActive = a_act; bus.A_WriteStrobe = a_stb; bus.A_WriteData = a_dat;
        bus.B_ComActive = b_act; bus.B_WriteStrobe = b_stb; bus.B_WriteData = b_dat;
    endtask

    task automatic test_reset();
        drive(0, 0, '0, 0, 0, '0);
        bus2.A_ComActive = 0; bus2.A_WriteStrobe = 0; bus2.A_WriteData = '0;
        bus2.B_ComActive = 0; bus2.B_WriteStrobe = 0; bus2.B_WriteData = '0;
        resetn = 0;
        tick(); tick();
        n_cmp++;
        if (obs_vec() !== 39'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
        end
        n_cmp++;
        if (dbg1 !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg1, ST_IDLE);
        end
        resetn = 1;
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_a_session();
        repeat (3) tick();
        drive(1, 0, '0, 0, 0, '0);
        tick();  // START
        n_cmp++;
        if ({bus.FSM_Reset, bus.A_Granted, dbg1} !== {2'b11, ST_START}) begin
            n_fail++; $display("FAIL a_start: got fr=%b g=%b st=%0d want 1 1 %0d",
                               bus.FSM_Reset, bus.A_Granted, dbg1, ST_START);
        end
        tick();  // OWN
        n_cmp++;
        if ({bus.FSM_Reset, bus.A_Granted, bus.ActiveSource} !== {2'b01, SRC_A}) begin
            n_fail++; $display("FAIL a_own: got fr=%b g=%b as=%b want 0 1 01",
                               bus.FSM_Reset, bus.A_Granted, bus.ActiveSource);
        end
        drive(1, 1, SYNC_WORD, 0, 0, '0);
        tick();
        n_cmp++;
        if ({bus.WriteStrobe, bus.WriteData} !== {1'b1, SYNC_WORD}) begin
            n_fail++; $display("FAIL a_sync_word: got ws=%b wd=%h want 1 %h",
                               bus.WriteStrobe, bus.WriteData, SYNC_WORD);
        end
        drive(1, 0, 32'h0, 0, 0, '0);
        tick();
        n_cmp++;
        if ({bus.WriteStrobe, bus.WriteData} !== {1'b0, SYNC_WORD}) begin
            n_fail++; $display("FAIL a_hold: got ws=%b wd=%h want 0 %h",
                               bus.WriteStrobe, bus.WriteData, SYNC_WORD);
        end
        drive(0, 0, '0, 0, 0, '0);
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.A_Granted !== 1'b0) begin
            n_fail++; $display("FAIL a_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_contention();
        resetn = 0; tick(); resetn = 1;
        drive(1, 0, '0, 1, 0, '0);
        tick();
        n_cmp++;
        if ({bus.A_Granted, bus.B_Granted, bus.FSM_Reset} !== 3'b101) begin
            n_fail++; $display("FAIL cont_first: got ag=%b bg=%b fr=%b want 1 0 1",
                               bus.A_Granted, bus.B_Granted, bus.FSM_Reset);
        end
        tick(); tick();
        drive(0, 0, '0, 1, 0, '0);
        tick();
        n_cmp++;
        if ({bus.ActiveSource, bus.FSM_Reset} !== {SRC_NONE, 1'b0}) begin
            n_fail++; $display("FAIL cont_gap: got as=%b fr=%b want 00 0",
                               bus.ActiveSource, bus.FSM_Reset);
        end
        tick();
        n_cmp++;
        if ({bus.B_Granted, bus.FSM_Reset, bus.ActiveSource} !== {2'b11, SRC_B}) begin
            n_fail++; $display("FAIL cont_b_start: got bg=%b fr=%b as=%b want 1 1 10",
                               bus.B_Granted, bus.FSM_Reset, bus.ActiveSource);
        end
        tick();
        drive(0, 0, '0, 0, 0, '0);
        tick();
        drive(1, 0, '0, 1, 0, '0);
        tick();
        n_cmp++;
        if ({bus.A_Granted, bus.B_Granted} !== 2'b10 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL cont_rr: got %h want %h", obs_vec(), exp_vec());
        end
        drive(0, 0, '0, 0, 0, '0);
        tick(); tick();
    endtask

    task automatic test_isolation();
        drive(1, 0, '0, 0, 0, '0);
        tick(); tick();
        drive(1, 1, 32'hA5A5_0001, 0, 0, '0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, '0, 1, 1, 32'h1234_5678);
            tick();
            n_cmp++;
            if ({bus.WriteStrobe, bus.WriteData} !== {1'b0, 32'hA5A5_0001}) begin
                n_fail++; $display("FAIL isolation: got ws=%b wd=%h want 0 a5a50001",
                                   bus.WriteStrobe, bus.WriteData);
            end
        end
        drive(0, 0, '0, 0, 0, '0);
        tick(); tick();
    endtask

    task automatic test_watchdog();
        drive(1, 0, '0, 0, 0, '0);
        tick();  // START for A
        drive(1, 0, '0, 1, 0, '0);
        for (int j = 1; j <= T_WD + 1; j++) begin
            tick();
            if (j <= T_WD) begin
                if (bus.A_Granted !== 1'b1 || bus.TimeoutEvent !== 1'b0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL wd_early: cycle %0d got ag=%b to=%b want 1 0",
                             j, bus.A_Granted, bus.TimeoutEvent);
                end
            end else begin
                n_cmp++;
                if ({bus.TimeoutEvent, bus.A_Granted, bus.ActiveSource} !== {2'b10, SRC_NONE}) begin
                    n_fail++; $display("FAIL wd_expire: got to=%b ag=%b as=%b want 1 0 00",
                                       bus.TimeoutEvent, bus.A_Granted, bus.ActiveSource);
                end
            end
        end
        tick();
        n_cmp++;
        if ({bus.B_Granted, bus.FSM_Reset, bus.TimeoutEvent} !== 3'b110) begin
            n_fail++; $display("FAIL wd_b_grant: got bg=%b fr=%b to=%b want 1 1 0",
                               bus.B_Granted, bus.FSM_Reset, bus.TimeoutEvent);
        end
        drive(1, 0, '0, 0, 0, '0);
        for (int j = 0; j < 5; j++) begin
            tick();
            n_cmp++;
            if (bus.A_Granted !== 1'b0) begin
                n_fail++; $display("FAIL wd_blocked: got ag=%b want 0", bus.A_Granted);
            end
        end
        drive(0, 0, '0, 0, 0, '0);
        tick();
        drive(1, 0, '0, 0, 0, '0);
        tick();
        n_cmp++;
        if ({bus.A_Granted, bus.FSM_Reset} !== 2'b11) begin
            n_fail++; $display("FAIL wd_unblock: got ag=%b fr=%b want 1 1",
                               bus.A_Granted, bus.FSM_Reset);
        end
        drive(0, 0, '0, 0, 0, '0);
        tick(); tick();
    endtask

    task automatic test_watchdog_disabled();
        bit bad;
        bad = 0;
        bus2.A_ComActive = 1;
        tick();
        n_cmp++;
        if ({bus2.A_Granted, bus2.FSM_Reset} !== 2'b11) begin
            n_fail++; $display("FAIL nowd_start: got ag=%b fr=%b want 1 1",
                               bus2.A_Granted, bus2.FSM_Reset);
        end
        for (int j = 0; j < 3000; j++) begin
            tick();
            if (bus2.TimeoutEvent !== 1'b0 || bus2.A_Granted !== 1'b1) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_fail++; $display("FAIL nowd_hold: got to=%b ag=%b want 0 1",
                               bus2.TimeoutEvent, bus2.A_Granted);
        end
        bus2.A_ComActive = 0;
        tick();
    endtask

    task automatic test_release_strobe();
        drive(1, 0, '0, 0, 0, '0);
        tick(); tick();
        drive(1, 1, 32'h0BAD_F00D, 0, 0, '0);
        resetn = 0;
        tick();
        n_cmp++;
        if (obs_vec() !== 39'd0 || dbg1 !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_mid: got %h st=%0d want 0 %0d", obs_vec(), dbg1, ST_IDLE);
        end
        resetn = 1;
        drive(1, 0, '0, 0, 0, '0);
        tick();
        n_cmp++;
        if ({bus.A_Granted, bus.FSM_Reset} !== 2'b11) begin
            n_fail++; $display("FAIL reset_regrant: got ag=%b fr=%b want 1 1",
                               bus.A_Granted, bus.FSM_Reset);
        end
        tick();
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, '0);
        tick();
        n_cmp++;
        if ({bus.WriteStrobe, bus.A_Granted} !== 2'b00 || bus.WriteData === 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL drop_on_release: got ws=%b ag=%b wd=%h want 0 0 not deadbeef",
                               bus.WriteStrobe, bus.A_Granted, bus.WriteData);
        end
        drive(0, 0, '0, 0, 0, '0);
        tick();
    endtask

    task automatic test_random();
        bit a_act, b_act, a_stb, b_stb;
        int unsigned stb_pct;
        a_act = 0; b_act = 0; stb_pct = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) stb_pct = $urandom_range(0, 60);
            if ($urandom_range(0, 47) == 0) a_act = !a_act;
            if ($urandom_range(0, 47) == 0) b_act = !b_act;
            a_stb = a_act && ($urandom_range(0, 99) < stb_pct);
            b_stb = b_act && ($urandom_range(0, 99) < stb_pct);
            resetn = ($urandom_range(0, 599) != 0);
            drive(a_act, a_stb, $urandom, b_act, b_stb, $urandom);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        resetn = 1;
        drive(0, 0, '0, 0, 0, '0);
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_a_session();
        test_contention();
        test_isolation();
        test_watchdog();
        test_watchdog_disabled();
        test_release_strobe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
